// File: rtl/iq_width_reducer.sv
// rtl/iq_width_reducer.sv - N-channel signed width reducer: shift, round, saturate, clip monitor
// Two-stage pipeline: stage 1 scales each channel, stage 2 saturates and tracks clip events.
module iq_width_reducer #(
  parameter int NUM_CH     = 2,
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 12,
  parameter int ROUND_MODE = 1,
  parameter int CNT_WIDTH  = 16,
  localparam int SHIFT_W   = $clog2(IN_WIDTH)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_valid,
  input  logic [NUM_CH*IN_WIDTH-1:0]     data_in,
  input  logic [SHIFT_W-1:0]             shift,
  input  logic                           ovf_clr,
  output logic                           out_valid,
  output logic [NUM_CH*OUT_WIDTH-1:0]    data_out,
  output logic [NUM_CH-1:0]              ovf,
  output logic [CNT_WIDTH-1:0]           clip_cnt
);

  localparam int YW = IN_WIDTH + 1;
  localparam logic [SHIFT_W-1:0]   MAX_SHIFT = SHIFT_W'(IN_WIDTH - 1);
  localparam logic signed [YW-1:0] SAT_MAX   = YW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [YW-1:0] SAT_MIN   = YW'(-(1 << (OUT_WIDTH - 1)));

  logic [SHIFT_W-1:0]          w_shift;
  logic signed [YW-1:0]        w_half;
  logic [NUM_CH*YW-1:0]        w_y_flat;
  logic [NUM_CH*OUT_WIDTH-1:0] w_sat_flat;
  logic [NUM_CH-1:0]           w_clip;
  logic                        w_any_clip;

  logic                        r_v1;
  logic [NUM_CH*YW-1:0]        r_y_flat;
  logic                        r_out_valid;
  logic [NUM_CH*OUT_WIDTH-1:0] r_data_out;
  logic [NUM_CH-1:0]           r_ovf;
  logic [CNT_WIDTH-1:0]        r_clip_cnt;

  // Out-of-range shift codes only exist when the shift field can exceed IN_WIDTH-1.
  generate
    if ((1 << SHIFT_W) > IN_WIDTH) begin : g_clamp
      assign w_shift = (shift > MAX_SHIFT) ? MAX_SHIFT : shift;
    end else begin : g_noclamp
      assign w_shift = shift;
    end
  endgenerate

  assign w_half = (w_shift == '0) ? '0 : (YW'(1) << (w_shift - 1'b1));

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      logic signed [YW-1:0] w_x;
      logic signed [YW-1:0] w_sum;
      logic signed [YW-1:0] w_r;

      // One guard bit keeps +full-scale plus the rounding half from wrapping.
      assign w_x   = {data_in[g*IN_WIDTH + IN_WIDTH - 1], data_in[g*IN_WIDTH +: IN_WIDTH]};
      assign w_sum = w_x + w_half;
      assign w_y_flat[g*YW +: YW] = (ROUND_MODE != 0) ? (w_sum >>> w_shift) : (w_x >>> w_shift);

      assign w_r = r_y_flat[g*YW +: YW];
      assign w_clip[g] = (w_r > SAT_MAX) || (w_r < SAT_MIN);
      assign w_sat_flat[g*OUT_WIDTH +: OUT_WIDTH] =
          (w_r > SAT_MAX) ? SAT_MAX[OUT_WIDTH-1:0] :
          (w_r < SAT_MIN) ? SAT_MIN[OUT_WIDTH-1:0] : w_r[OUT_WIDTH-1:0];
    end
  endgenerate

  assign w_any_clip = r_v1 && (|w_clip);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1     <= 1'b0;
      r_y_flat <= '0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_y_flat <= w_y_flat;
      end
    end
  end

  // A clip arriving together with ovf_clr wins, so the event is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
      r_ovf       <= '0;
      r_clip_cnt  <= '0;
    end else begin
      r_out_valid <= r_v1;
      if (r_v1) begin
        r_data_out <= w_sat_flat;
      end
      if (ovf_clr) begin
        r_ovf      <= r_v1 ? w_clip : '0;
        r_clip_cnt <= w_any_clip ? CNT_WIDTH'(1) : '0;
      end else begin
        r_ovf <= r_ovf | (r_v1 ? w_clip : '0);
        if (w_any_clip && (r_clip_cnt != '1)) begin
          r_clip_cnt <= r_clip_cnt + 1'b1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign ovf       = r_ovf;
  assign clip_cnt  = r_clip_cnt;

endmodule

// File: tb/tb_iq_width_reducer.sv
// tb/tb_iq_width_reducer.sv - directed bench for iq_width_reducer (rounding and truncating instances)
// Both instances share stimulus; the truncating one uses a 4-bit clip counter.
module tb_iq_width_reducer;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] data_in;
  logic [3:0]  shift;
  logic        ovf_clr;

  logic        r_ov,  t_ov;
  logic [23:0] r_do,  t_do;
  logic [1:0]  r_ovf, t_ovf;
  logic [15:0] r_cnt;
  logic [3:0]  t_cnt;

  int n_checks = 0;
  int n_errors = 0;

  iq_width_reducer #(.NUM_CH(2), .IN_WIDTH(16), .OUT_WIDTH(12), .ROUND_MODE(1), .CNT_WIDTH(16)) u_rnd (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .data_in(data_in), .shift(shift),
    .ovf_clr(ovf_clr), .out_valid(r_ov), .data_out(r_do), .ovf(r_ovf), .clip_cnt(r_cnt));

  iq_width_reducer #(.NUM_CH(2), .IN_WIDTH(16), .OUT_WIDTH(12), .ROUND_MODE(0), .CNT_WIDTH(4)) u_trn (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .data_in(data_in), .shift(shift),
    .ovf_clr(ovf_clr), .out_valid(t_ov), .data_out(t_do), .ovf(t_ovf), .clip_cnt(t_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input int q, input int s);
    logic [31:0] w_i, w_q;
    w_i = i;
    w_q = q;
    data_in  = {w_q[15:0], w_i[15:0]};
    shift    = 4'(s);
    in_valid = 1'b1;
  endtask

  // Drives one sample and waits the two-cycle latency so outputs are current.
  task automatic send(input int i, input int q, input int s);
    drive(i, q, s);
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  function automatic int ref_red(input int x, input int s, input bit rnd);
    int d, v, q;
    d = 1 << s;
    v = (rnd && s > 0) ? x + d / 2 : x;
    q = v / d;
    if (v < 0 && (v % d) != 0) q = q - 1;
    if (q > 2047) q = 2047;
    if (q < -2048) q = -2048;
    return q;
  endfunction

  function automatic logic [23:0] pack(input int i, input int q);
    logic [31:0] w_i, w_q;
    w_i = i;
    w_q = q;
    return {w_q[11:0], w_i[11:0]};
  endfunction

  logic [23:0] exp_r [$];
  logic [23:0] exp_t [$];

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_out;
    bit saw_valid;
    int xi, xq, s;
    logic [23:0] e;

    reset_n = 1'b0; in_valid = 1'b0; data_in = '0; shift = '0; ovf_clr = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'd0, r_ov}, 32'd0);
    chk("rst_data",  {8'd0, r_do}, 32'd0);
    chk("rst_ovf",   {30'd0, t_ovf}, 32'd0);
    chk("rst_cnt",   {16'd0, r_cnt}, 32'd0);
    reset_n = 1'b1;
    tick();

    // T1 legacy shift
    send(32'h1234, 32'hFFFFFEDC, 4);
    chk("t1_valid",   {31'd0, t_ov}, 32'd1);
    chk("t1_trn",     {8'd0, t_do}, 32'h00FED123);
    chk("t1_rnd",     {8'd0, r_do}, 32'h00FEE123);
    chk("t1_ovf",     {30'd0, t_ovf}, 32'd0);
    chk("t1_cnt",     {16'd0, r_cnt}, 32'd0);
    tick();
    chk("t1_vdrop",   {31'd0, r_ov}, 32'd0);
    chk("t1_hold",    {8'd0, r_do}, 32'h00FEE123);

    // T2 rounding vs truncation
    send(24, -24, 4);
    chk("t2_rnd", {8'd0, r_do}, 32'h00FFF002);
    chk("t2_trn", {8'd0, t_do}, 32'h00FFE001);

    // T3 saturation and rounding edge at +full scale
    send(32'h7FFF, 32'hFFFF8000, 0);
    chk("t3_sat_r",  {8'd0, r_do}, 32'h008007FF);
    chk("t3_sat_t",  {8'd0, t_do}, 32'h008007FF);
    chk("t3_ovf",    {30'd0, r_ovf}, 32'd3);
    chk("t3_cnt_r",  {16'd0, r_cnt}, 32'd1);
    send(32'h7FFF, 0, 4);
    chk("t3_edge_r", {8'd0, r_do}, 32'h000007FF);
    chk("t3_edge_t", {8'd0, t_do}, 32'h000007FF);
    chk("t3_cnt2_r", {16'd0, r_cnt}, 32'd2);
    chk("t3_cnt2_t", {28'd0, t_cnt}, 32'd1);

    // T4 back-to-back stream with alternating shift
    n_out = 0;
    for (int cyc = 0; cyc < 104; cyc++) begin
      if (cyc < 100) begin
        xi = cyc * 37 - 1800;
        xq = 1700 - cyc * 29;
        s  = (cyc % 2 == 1) ? 3 : 0;
        drive(xi, xq, s);
        exp_r.push_back(pack(ref_red(xi, s, 1'b1), ref_red(xq, s, 1'b1)));
        exp_t.push_back(pack(ref_red(xi, s, 1'b0), ref_red(xq, s, 1'b0)));
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (r_ov) begin
        n_out++;
        if (exp_r.size() == 0) begin
          chk("t4_extra", 32'd1, 32'd0);
        end else begin
          e = exp_r.pop_front();
          chk("t4_rnd", {8'd0, r_do}, {8'd0, e});
          e = exp_t.pop_front();
          chk("t4_trn", {8'd0, t_do}, {8'd0, e});
        end
      end
    end
    chk("t4_count", n_out, 32'd100);
    chk("t4_cnt",   {16'd0, r_cnt}, 32'd2);

    // T5 clear racing a clip event, then clear alone
    drive(32'h7FFF, 32'hFFFF8000, 0);
    tick();
    in_valid = 1'b0;
    ovf_clr  = 1'b1;
    tick();
    chk("t5_ovf",  {30'd0, r_ovf}, 32'd3);
    chk("t5_cnt",  {16'd0, r_cnt}, 32'd1);
    tick();
    ovf_clr = 1'b0;
    chk("t5_ovf0", {30'd0, r_ovf}, 32'd0);
    chk("t5_cnt0", {16'd0, r_cnt}, 32'd0);

    // T6 reset with two samples in flight
    send(32'h7FFF, 32'hFFFF8000, 0);
    chk("t6_pre_cnt", {16'd0, r_cnt}, 32'd1);
    drive(32'h7FFF, 32'hFFFF8000, 0);
    tick();
    drive(32'h7FFF, 32'hFFFF8000, 0);
    reset_n = 1'b0;
    #1;
    chk("t6_valid", {31'd0, r_ov}, 32'd0);
    chk("t6_data",  {8'd0, r_do}, 32'd0);
    chk("t6_ovf",   {30'd0, r_ovf}, 32'd0);
    chk("t6_cnt",   {16'd0, r_cnt}, 32'd0);
    tick();
    reset_n  = 1'b1;
    in_valid = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (r_ov || t_ov) saw_valid = 1'b1;
    end
    chk("t6_no_valid", {31'd0, saw_valid}, 32'd0);

    // Clip counter saturation: 20 clipped samples
    for (int k = 0; k < 20; k++) begin
      drive(32'h7FFF, 0, 0);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("t6_sat_t", {28'd0, t_cnt}, 32'd15);
    chk("t6_sat_r", {16'd0, r_cnt}, 32'd20);
    chk("t6_ovf_t", {30'd0, t_ovf}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t6_clr_t", {28'd0, t_cnt}, 32'd0);
    chk("t6_clr_o", {30'd0, t_ovf}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
